// File: rtl/can_reg_arb.sv
// can_reg_arb: two-master round-robin arbiter for a single CAN controller
// register port. Each master holds req until it sees its one-cycle ack.
// The FSM walks IDLE -> ACCESS -> (RD_WAIT) -> DONE -> IDLE.
//
// Handshake: a master raises mN_req_i with we/addr/wdata stable and holds it
// until mN_ack_o pulses. The ack is a single-cycle pulse, and read data is
// already valid on mN_rdata_o in the ack cycle. A req that is high in the
// cycle after the ack starts a new transaction.
module can_reg_arb #(
  parameter int RD_LAT = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       m0_req_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_addr_i,
  input  logic [7:0] m0_wdata_i,
  output logic       m0_ack_o,
  output logic [7:0] m0_rdata_o,
  input  logic       m1_req_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_addr_i,
  input  logic [7:0] m1_wdata_i,
  output logic       m1_ack_o,
  output logic [7:0] m1_rdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_data_in_o,
  input  logic [7:0] reg_data_out_i,
  output logic       reg_rst_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  logic [1:0] r_state;
  logic       r_last;     // 1 = m1 was granted last
  logic       r_sel;      // current winner, 1 = m1
  logic       r_we;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [2:0] r_cnt;
  logic [7:0] r_rdata0;
  logic [7:0] r_rdata1;
  logic       r_reg_rst;

  logic       w_any_req;
  logic       w_grant_m1;
  logic       w_access;
  logic       w_done;

  // On a tie the master that was not granted last wins.
  assign w_any_req  = m0_req_i | m1_req_i;
  assign w_grant_m1 = (m0_req_i & m1_req_i) ? ~r_last : m1_req_i;

  // Main FSM: grant, strobe, optional read wait, completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
      r_cnt    <= 3'd0;
      r_rdata0 <= 8'h00;
      r_rdata1 <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_sel   <= w_grant_m1;
            r_last  <= w_grant_m1;
            r_we    <= w_grant_m1 ? m1_we_i    : m0_we_i;
            r_addr  <= w_grant_m1 ? m1_addr_i  : m0_addr_i;
            r_wdata <= w_grant_m1 ? m1_wdata_i : m0_wdata_i;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= 3'd1;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (r_cnt == LAT) begin
            if (r_sel) r_rdata1 <= reg_data_out_i;
            else       r_rdata0 <= reg_data_out_i;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Register-port reset is a one-cycle delayed copy of the block reset.
  always_ff @(posedge clk_i) begin
    r_reg_rst <= rst_i;
  end

  // A reset in the strobe or ack cycle aborts the transaction, so the
  // strobes and acks are masked while rst_i is high.
  assign w_access = (r_state == S_ACCESS) & ~rst_i;
  assign w_done   = (r_state == S_DONE) & ~rst_i;

  assign reg_we_o      = w_access & r_we;
  assign reg_re_o      = w_access & ~r_we;
  assign reg_addr_o    = r_addr;
  assign reg_data_in_o = r_wdata;
  assign reg_rst_o     = r_reg_rst;

  assign m0_ack_o   = w_done & ~r_sel;
  assign m1_ack_o   = w_done & r_sel;
  assign m0_rdata_o = r_rdata0;
  assign m1_rdata_o = r_rdata1;

  assign state_o = r_state;

endmodule

// File: tb/tb_can_reg_arb.sv
// tb_can_reg_arb: directed and randomized stimulus for can_reg_arb, checked
// against a transaction-level reference model. The model records each grant
// as a transaction with a grant cycle and an ack cycle, and derives the
// expected outputs of every cycle from those timestamps.
module tb_can_reg_arb;

  localparam int RD_LAT = 3;

  // clock / reset
  logic clk;
  logic rst_i;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [7:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic       m0_ack_o, m1_ack_o;
  logic [7:0] m0_rdata_o, m1_rdata_o;
  logic       reg_we_o, reg_re_o, reg_rst_o;
  logic [7:0] reg_addr_o, reg_data_in_o, reg_data_out_i;
  logic [1:0] state_o;

  can_reg_arb #(.RD_LAT(RD_LAT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .m0_req_i       (m0_req_i),
    .m0_we_i        (m0_we_i),
    .m0_addr_i      (m0_addr_i),
    .m0_wdata_i     (m0_wdata_i),
    .m0_ack_o       (m0_ack_o),
    .m0_rdata_o     (m0_rdata_o),
    .m1_req_i       (m1_req_i),
    .m1_we_i        (m1_we_i),
    .m1_addr_i      (m1_addr_i),
    .m1_wdata_i     (m1_wdata_i),
    .m1_ack_o       (m1_ack_o),
    .m1_rdata_o     (m1_rdata_o),
    .reg_we_o       (reg_we_o),
    .reg_re_o       (reg_re_o),
    .reg_addr_o     (reg_addr_o),
    .reg_data_in_o  (reg_data_in_o),
    .reg_data_out_i (reg_data_out_i),
    .reg_rst_o      (reg_rst_o),
    .state_o        (state_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model: one outstanding transaction plus visible registers
  bit       act;
  bit       am;
  bit       awe;
  int       tg;
  int       tack;
  bit       last_m1;
  bit [7:0] m_addr;
  bit [7:0] m_wd;
  bit [7:0] m_rd [2];
  bit       prev_rst;

  // per-master stimulus state
  bit       pend [2];
  bit       drop [2];
  bit       s_we [2];
  bit [7:0] s_addr [2];
  bit [7:0] s_wd [2];

  bit       rd_fixed_en;
  bit [7:0] rd_fixed;

  // scoreboard comparison
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    act      = 1'b0;
    last_m1  = 1'b1;
    m_addr   = 8'h00;
    m_wd     = 8'h00;
    m_rd[0]  = 8'h00;
    m_rd[1]  = 8'h00;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0;
      drop[m] = 1'b0;
    end
  endtask

  task automatic set_req(input int m, input bit we, input bit [7:0] addr, input bit [7:0] wd);
    pend[m]   = 1'b1;
    drop[m]   = 1'b0;
    s_we[m]   = we;
    s_addr[m] = addr;
    s_wd[m]   = wd;
  endtask

  // random request generator; we_mode 0 = read, 1 = write, 2 = random
  task automatic gen(input int p_req, input int p_drop, input int we_mode);
    for (int m = 0; m < 2; m++) begin
      if (!pend[m]) begin
        if (int'($urandom_range(0, 99)) < p_req)
          set_req(m, (we_mode == 2) ? 1'($urandom_range(0, 1)) : (we_mode == 1),
                  8'($urandom), 8'($urandom));
      end else if (act && am == 1'(m) && cyc > tg && !drop[m] &&
                   int'($urandom_range(0, 99)) < p_drop) begin
        drop[m] = 1'b1;
      end
    end
  endtask

  // driver + checker + model advance for one clock cycle
  task automatic cycle(input bit rst);
    bit       rq0, rq1, w;
    bit [7:0] d;
    rst_i          = rst;
    m0_req_i       = pend[0] && !drop[0];
    m0_we_i        = s_we[0];
    m0_addr_i      = s_addr[0];
    m0_wdata_i     = s_wd[0];
    m1_req_i       = pend[1] && !drop[1];
    m1_we_i        = s_we[1];
    m1_addr_i      = s_addr[1];
    m1_wdata_i     = s_wd[1];
    reg_data_out_i = rd_fixed_en ? rd_fixed : 8'($urandom);
    @(negedge clk);
    chk("reg_we",      reg_we_o,  8'(!rst && act && awe  && cyc == tg + 1));
    chk("reg_re",      reg_re_o,  8'(!rst && act && !awe && cyc == tg + 1));
    chk("m0_ack",      m0_ack_o,  8'(!rst && act && !am && cyc == tack));
    chk("m1_ack",      m1_ack_o,  8'(!rst && act &&  am && cyc == tack));
    chk("reg_addr",    reg_addr_o,    m_addr);
    chk("reg_data_in", reg_data_in_o, m_wd);
    chk("m0_rdata",    m0_rdata_o,    m_rd[0]);
    chk("m1_rdata",    m1_rdata_o,    m_rd[1]);
    chk("reg_rst",     reg_rst_o,     8'(prev_rst));
    chk("state_known", 8'(!$isunknown(state_o)), 8'd1);
    // model update at the coming rising edge
    rq0 = m0_req_i;
    rq1 = m1_req_i;
    d   = reg_data_out_i;
    if (rst) begin
      model_reset();
    end else if (act) begin
      if (!awe && cyc == tack - 1) m_rd[am] = d;
      if (cyc == tack) begin
        act      = 1'b0;
        pend[am] = 1'b0;
        drop[am] = 1'b0;
      end
    end else if (rq0 || rq1) begin
      w       = (rq0 && rq1) ? !last_m1 : rq1;
      last_m1 = w;
      act     = 1'b1;
      am      = w;
      awe     = s_we[w];
      m_addr  = s_addr[w];
      m_wd    = s_wd[w];
      tg      = cyc;
      tack    = awe ? cyc + 2 : cyc + 2 + RD_LAT;
    end
    prev_rst = rst;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit did;
    int start;
    // power-on reset, outputs unknown until the first sampled reset edge
    rst_i = 1'b1;
    m0_req_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = 8'h00; m0_wdata_i = 8'h00;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = 8'h00; m1_wdata_i = 8'h00;
    reg_data_out_i = 8'h00;
    rd_fixed_en = 1'b0;
    rd_fixed    = 8'h00;
    for (int m = 0; m < 2; m++) begin
      s_we[m] = 1'b0; s_addr[m] = 8'h00; s_wd[m] = 8'h00;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    prev_rst = 1'b1;
    cyc = 0;
    cycle(1'b0);  // reset state

    // m0 write 0x04 <= 0x5A
    set_req(0, 1'b1, 8'h04, 8'h5A);
    repeat (4) cycle(1'b0);

    // m1 read 0x02 with register port returning 0xC3
    rd_fixed_en = 1'b1;
    rd_fixed    = 8'hC3;
    set_req(1, 1'b0, 8'h02, 8'h00);
    repeat (8) cycle(1'b0);
    rd_fixed_en = 1'b0;

    // m0 grant so the last pointer points at m0, then reset restores m1
    set_req(0, 1'b1, 8'h10, 8'h33);
    repeat (4) cycle(1'b0);
    cycle(1'b1);

    // simultaneous continuous writes alternate m0, m1, m0, m1
    for (int i = 0; i < 24; i++) begin
      gen(100, 0, 1);
      cycle(1'b0);
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (4) cycle(1'b0);

    // m0 read held through ack, write requested in the very next cycle
    set_req(0, 1'b0, 8'h21, 8'h00);
    did   = 1'b0;
    start = cyc;
    for (int i = 0; i < 14; i++) begin
      if (!pend[0] && !did && cyc > start) begin
        set_req(0, 1'b1, 8'h22, 8'h7E);
        did = 1'b1;
      end
      cycle(1'b0);
    end

    // reset pulse while m0 read is waiting on data
    set_req(0, 1'b0, 8'h30, 8'h00);
    repeat (3) cycle(1'b0);
    cycle(1'b1);
    repeat (6) cycle(1'b0);
    set_req(1, 1'b1, 8'h31, 8'hA5);
    repeat (4) cycle(1'b0);

    // randomized traffic, including masters dropping req early
    for (int i = 0; i < 500; i++) begin
      gen(40, 5, 2);
      cycle(1'b0);
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (8) cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
